// File: rtl/crypto_pkg.sv
// Shared definitions for the 8-bit cryptosystem datapath.
//   state_t            : controller FSM encoding (IDLE/ROUND/DONE)
//   NUM_ROUNDS_DEFAULT : default round count
//   BYTE_W, RIDX_W     : data byte and round-index widths
//   rotl8 / rotr8      : byte rotations by 0..7
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_ROUNDS_DEFAULT = 4;
  localparam int BYTE_W             = 8;
  localparam int RIDX_W             = 4;

  // Rotate via a doubled copy so a zero amount needs no special case.
  function automatic logic [BYTE_W-1:0] rotl8(input logic [BYTE_W-1:0] x,
                                              input logic [2:0] n);
    logic [2*BYTE_W-1:0] t;
    t = {x, x} << n;
    return t[2*BYTE_W-1:BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] rotr8(input logic [BYTE_W-1:0] x,
                                              input logic [2:0] n);
    logic [2*BYTE_W-1:0] t;
    t = {x, x} >> n;
    return t[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/cipher_round_keygen.sv
// Combinational round-key generator: rk = rotl8(key, ridx mod 8) ^ ridx.
//   key  : master key
//   ridx : round index 0..15
//   rk   : round key
module cipher_round_keygen
  import crypto_pkg::*;
(
  input  logic [BYTE_W-1:0] key,
  input  logic [RIDX_W-1:0] ridx,
  output logic [BYTE_W-1:0] rk
);
  assign rk = rotl8(key, ridx[2:0]) ^ {{(BYTE_W-RIDX_W){1'b0}}, ridx};
endmodule

// File: rtl/inverse_substitution_block.sv
// Inverse byte S-box: undoes substitution_block nibble by nibble.
//   in : substituted byte
//   c  : original byte
module inverse_substitution_block (
  input  logic [7:0] in,
  output logic [7:0] c
);
  // Nibble i of TBL is S^-1(i).
  localparam logic [63:0] TBL = 64'hA970364BD21C8FE5;

  assign c = {TBL[{in[7:4], 2'b00} +: 4], TBL[{in[3:0], 2'b00} +: 4]};
endmodule

// File: rtl/substitution_block.sv
// Forward byte S-box: applies a 4-bit bijective S-box to each nibble.
//   in : byte to substitute
//   c  : substituted byte
module substitution_block (
  input  logic [7:0] in,
  output logic [7:0] c
);
  // Nibble i of TBL is S(i).
  localparam logic [63:0] TBL = 64'h21748FE3DA09B65C;

  assign c = {TBL[{in[7:4], 2'b00} +: 4], TBL[{in[3:0], 2'b00} +: 4]};
endmodule

// File: rtl/cipher_round_controller.sv
// Iterative byte cipher controller: one S-box pair reused over NUM_ROUNDS
// rounds, one round per cycle, with valid/ready on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake (mode, key, data_in sampled on accept)
//   out_valid/out_ready : result handshake (data_out held while out_valid)
//   busy                : transaction in ROUND or DONE
//   round_idx           : round counter of the current ROUND cycle (debug)
module cipher_round_controller
  import crypto_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [BYTE_W-1:0] key,
  input  logic [BYTE_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] data_out,
  output logic              busy,
  output logic [RIDX_W-1:0] round_idx
);

  localparam logic [RIDX_W-1:0] NR   = RIDX_W'(NUM_ROUNDS);
  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(NUM_ROUNDS - 1);

  state_t            state, state_nxt;
  logic [BYTE_W-1:0] s_q, key_q, data_out_q;
  logic [RIDX_W-1:0] cnt_q;
  logic              mode_q;

  logic              accept, last_round;
  logic [BYTE_W-1:0] rk_cur, rk_wh, wh_key;
  logic [BYTE_W-1:0] sb_in, sb_out, isb_in, isb_out;
  logic [BYTE_W-1:0] enc_s, dec_s, round_s, result;

  // The whitening key is needed at accept for decrypt (from the live key)
  // and on the last encrypt round (from the captured key).
  assign wh_key = (state == IDLE) ? key : key_q;

  cipher_round_keygen u_kg_cur (.key(key_q),  .ridx(cnt_q), .rk(rk_cur));
  cipher_round_keygen u_kg_wh  (.key(wh_key), .ridx(NR),    .rk(rk_wh));

  assign sb_in  = s_q ^ rk_cur;
  assign isb_in = rotr8(s_q, 3'd1);

  substitution_block         u_sbox  (.in(sb_in),  .c(sb_out));
  inverse_substitution_block u_isbox (.in(isb_in), .c(isb_out));

  assign enc_s      = rotl8(sb_out, 3'd1);
  assign dec_s      = isb_out ^ rk_cur;
  assign round_s    = mode_q ? dec_s : enc_s;
  assign result     = mode_q ? dec_s : (enc_s ^ rk_wh);
  assign last_round = mode_q ? (cnt_q == '0) : (cnt_q == LAST);
  assign accept     = in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = ROUND;
      ROUND:   if (last_round) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mode_q <= mode;
          key_q  <= key;
          s_q    <= mode ? (data_in ^ rk_wh) : data_in;
          cnt_q  <= mode ? LAST : '0;
        end
        ROUND: begin
          // Counter is left on the last round so round_idx holds it in DONE.
          if (last_round) data_out_q <= result;
          else begin
            s_q   <= round_s;
            cnt_q <= mode_q ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = data_out_q;
  assign round_idx = (state == IDLE) ? '0 : cnt_q;

endmodule

// File: tb/tb_cipher_round_controller.sv
module tb_cipher_round_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 0, mode = 0, out_ready = 0;
  logic [7:0] key = 0, data_in = 0;
  logic       in_ready, out_valid, busy;
  logic [7:0] data_out;
  logic [3:0] round_idx;

  logic       in_valid1 = 0, mode1 = 0, out_ready1 = 0;
  logic [7:0] key1 = 0, data_in1 = 0;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] data_out1;
  logic [3:0] round_idx1;

  cipher_round_controller #(.NUM_ROUNDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .key(key), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy), .round_idx(round_idx));

  cipher_round_controller #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .mode(mode1), .key(key1), .data_in(data_in1), .out_valid(out_valid1),
    .out_ready(out_ready1), .data_out(data_out1), .busy(busy1), .round_idx(round_idx1));

  int n_chk = 0, n_pass = 0;

  // ---------------- reference model ----------------
  int sb4 [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  function automatic int sbox(input int b);
    return (sb4[(b >> 4) & 15] << 4) | sb4[b & 15];
  endfunction

  function automatic int inv_sbox(input int b);
    for (int v = 0; v < 256; v++) if (sbox(v) == b) return v;
    return -1;
  endfunction

  function automatic int rot_l(input int x, input int n);
    return ((x << (n % 8)) | (x >> (8 - (n % 8)))) & 255;
  endfunction

  function automatic int rkey(input int k, input int r);
    return rot_l(k, r) ^ r;
  endfunction

  function automatic logic [7:0] m_enc(input int k, input int d, input int n);
    int s = d;
    for (int r = 0; r < n; r++) s = rot_l(sbox(s ^ rkey(k, r)), 1);
    return 8'(s ^ rkey(k, n));
  endfunction

  function automatic logic [7:0] m_dec(input int k, input int d, input int n);
    int s = d ^ rkey(k, n);
    for (int r = n - 1; r >= 0; r--) s = inv_sbox(rot_l(s, 7)) ^ rkey(k, r);
    return 8'(s);
  endfunction

  // ---------------- driver ----------------
  // Issues one request to the N=4 instance; returns result and edges from
  // accept to out_valid (or 99 on timeout). Releases the result afterwards.
  task automatic run_txn(input logic m, input logic [7:0] k, input logic [7:0] d,
                         output logic [7:0] res, output int lat);
    @(negedge clk);
    in_valid = 1; mode = m; key = k; data_in = d; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = 99;
    res = data_out;
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    #3;
    if ({in_ready, out_valid, busy, data_out, round_idx} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      $display("FAIL reset_hold: got rdy=%b ov=%b busy=%b do=%h ri=%h want 1 0 0 00 0",
               in_ready, out_valid, busy, data_out, round_idx);
    end else n_pass++;
    n_chk++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    if ({in_ready, out_valid, busy, data_out, round_idx} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      $display("FAIL reset_release: got rdy=%b ov=%b busy=%b do=%h ri=%h want 1 0 0 00 0",
               in_ready, out_valid, busy, data_out, round_idx);
    end else n_pass++;
    n_chk++;
  endtask

  task automatic test_round_trip();
    logic [7:0] c, p, k;
    int lat;
    int bytes [4] = '{8'h62, 8'h17, 8'h52, 8'h7D};
    foreach (bytes[i]) begin
      run_txn(1'b0, 8'hA5, 8'(bytes[i]), c, lat);
      if (c !== m_enc(8'hA5, bytes[i], 4) || lat != 4) begin
        $display("FAIL enc_named d=%h: got %h lat %0d want %h lat 4", bytes[i], c, lat, m_enc(8'hA5, bytes[i], 4));
      end else n_pass++;
      n_chk++;
      run_txn(1'b1, 8'hA5, c, p, lat);
      if (p !== 8'(bytes[i]) || lat != 4) begin
        $display("FAIL dec_named c=%h: got %h lat %0d want %h lat 4", c, p, lat, bytes[i]);
      end else n_pass++;
      n_chk++;
    end
    for (int d = 0; d < 256; d++) begin
      run_txn(1'b0, 8'hA5, 8'(d), c, lat);
      if (c !== m_enc(8'hA5, d, 4)) begin
        $display("FAIL enc_all d=%h: got %h want %h", d, c, m_enc(8'hA5, d, 4));
      end else n_pass++;
      n_chk++;
      run_txn(1'b1, 8'hA5, c, p, lat);
      if (p !== 8'(d)) begin
        $display("FAIL dec_all c=%h: got %h want %h", c, p, d);
      end else n_pass++;
      n_chk++;
    end
    // Random keys and data, random direction, checked against the model.
    for (int i = 0; i < 60; i++) begin
      logic m;
      logic [7:0] d, e;
      m = 1'($urandom); k = 8'($urandom); d = 8'($urandom);
      e = m ? m_dec(k, d, 4) : m_enc(k, d, 4);
      run_txn(m, k, d, c, lat);
      if (c !== e || lat != 4) begin
        $display("FAIL rand m=%b k=%h d=%h: got %h lat %0d want %h lat 4", m, k, d, c, lat, e);
      end else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_latency();
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      in_valid = 1; mode = 1'(m); key = 8'h3C; data_in = 8'h99; out_ready = 0;
      @(posedge clk); #1; in_valid = 0;
      // Rounds 0..3 visible after accept edge and the next three edges.
      for (int c = 0; c < 4; c++) begin
        int er;
        er = m ? 3 - c : c;
        if ({busy, out_valid, in_ready, round_idx} !== {1'b1, 1'b0, 1'b0, 4'(er)}) begin
          $display("FAIL lat_round m=%0d c=%0d: got busy=%b ov=%b rdy=%b ri=%0d want 1 0 0 %0d",
                   m, c, busy, out_valid, in_ready, round_idx, er);
        end else n_pass++;
        n_chk++;
        @(posedge clk); #1;
      end
      if ({busy, out_valid, round_idx} !== {1'b1, 1'b1, 4'(m ? 0 : 3)}) begin
        $display("FAIL lat_done m=%0d: got busy=%b ov=%b ri=%0d want 1 1 %0d",
                 m, busy, out_valid, round_idx, m ? 0 : 3);
      end else n_pass++;
      n_chk++;
      @(negedge clk); out_ready = 1;
      @(posedge clk); #1; out_ready = 0;
      if ({busy, out_valid, in_ready, round_idx} !== {1'b0, 1'b0, 1'b1, 4'h0}) begin
        $display("FAIL lat_idle m=%0d: got busy=%b ov=%b rdy=%b ri=%0d want 0 0 1 0",
                 m, busy, out_valid, in_ready, round_idx);
      end else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] e;
    int w;
    bit bad;
    e = m_enc(8'h5A, 8'hC3, 4);
    @(negedge clk);
    in_valid = 1; mode = 0; key = 8'h5A; data_in = 8'hC3; out_ready = 0;
    @(posedge clk); #1; in_valid = 0;
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin @(negedge clk); in_valid = 1; mode = 1; data_in = 8'h11; end
      if (c == 6) begin @(negedge clk); in_valid = 0; end
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || data_out !== e || in_ready !== 1'b0) bad = 1;
    end
    if (bad) begin
      $display("FAIL back_pressure_hold: got ov=%b do=%h rdy=%b want 1 %h 0", out_valid, data_out, in_ready, e);
    end else n_pass++;
    n_chk++;
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      $display("FAIL back_pressure_release: got ov=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end else n_pass++;
    n_chk++;
    // The pulsed request must not have started a transaction.
    @(posedge clk); #1;
    if (busy !== 1'b0) begin
      $display("FAIL back_pressure_ignored: got busy=%b want 0", busy);
    end else n_pass++;
    n_chk++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] c;
    int lat;
    @(negedge clk);
    in_valid = 1; mode = 0; key = 8'hE1; data_in = 8'h4D;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (round_idx !== 4'd2) begin
      $display("FAIL reset_mid_round: got ri=%0d want 2", round_idx);
    end else n_pass++;
    n_chk++;
    #2 rst_n = 0;
    #1;
    if ({out_valid, busy, data_out, round_idx, in_ready} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b1}) begin
      $display("FAIL reset_mid_outputs: got ov=%b busy=%b do=%h ri=%0d rdy=%b want 0 0 00 0 1",
               out_valid, busy, data_out, round_idx, in_ready);
    end else n_pass++;
    n_chk++;
    @(negedge clk); rst_n = 1;
    run_txn(1'b0, 8'hE1, 8'h4D, c, lat);
    if (c !== m_enc(8'hE1, 8'h4D, 4) || lat != 4) begin
      $display("FAIL reset_mid_fresh: got %h lat %0d want %h lat 4", c, lat, m_enc(8'hE1, 8'h4D, 4));
    end else n_pass++;
    n_chk++;
  endtask

  task automatic test_one_round();
    logic [7:0] c, e;
    int lat;
    e = 8'(rot_l(sbox(0), 1) ^ 1);
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      in_valid1 = 1; mode1 = 1'(m); key1 = 8'h00; data_in1 = m ? c : 8'h00; out_ready1 = 0;
      @(posedge clk); #1; in_valid1 = 0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
      if (data_out1 !== (m ? 8'h00 : e) || lat != 1 || !out_valid1) begin
        $display("FAIL one_round m=%0d: got %h lat %0d want %h lat 1", m, data_out1, lat, m ? 8'h00 : e);
      end else n_pass++;
      n_chk++;
      c = data_out1;
      @(negedge clk); out_ready1 = 1;
      @(posedge clk); #1; out_ready1 = 0;
    end
  endtask

  task automatic test_key_change();
    for (int i = 0; i < 8; i++) begin
      logic m;
      logic [7:0] k, d, e;
      int w;
      m = 1'(i); k = 8'($urandom); d = 8'($urandom);
      e = m ? m_dec(k, d, 4) : m_enc(k, d, 4);
      @(negedge clk);
      in_valid = 1; mode = m; key = k; data_in = d;
      @(posedge clk); #1; in_valid = 0;
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk); key = 8'($urandom); mode = ~m; data_in = 8'($urandom);
        @(posedge clk); #1; w++;
      end
      if (data_out !== e || !out_valid) begin
        $display("FAIL key_change m=%b k=%h d=%h: got %h want %h", m, k, d, data_out, e);
      end else n_pass++;
      n_chk++;
      @(negedge clk); out_ready = 1;
      @(posedge clk); #1; out_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_trip();
    test_back_pressure();
    test_reset_mid();
    test_one_round();
    test_key_change();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
